// File: rtl/lockin_acquisition_sequencer_if.sv
// Control, datapath-snapshot and result-readout signals of the lock-in acquisition sequencer.
// The master side drives commands, configuration, datapath snapshots and res_ready; the slave is the sequencer.
interface lockin_acquisition_sequencer_if #(
    parameter int ACC_W = 48
);
    logic             start;
    logic             abort;
    logic [31:0]      cfg_window_cycles;
    logic [15:0]      cfg_num_windows;
    logic             cfg_dark_enable;
    logic             busy;
    logic             light_enable;
    logic             count_clear;
    logic             count_enable;
    logic             count_latch;
    logic             dp_valid;
    logic [31:0]      dp_in_phase;
    logic [31:0]      dp_quadrature;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_in_phase;
    logic [ACC_W-1:0] res_quadrature;
    logic [15:0]      res_windows;
    logic [1:0]       res_flags;

    modport master (
        output start, abort, cfg_window_cycles, cfg_num_windows, cfg_dark_enable,
        output dp_valid, dp_in_phase, dp_quadrature, res_ready,
        input  busy, light_enable, count_clear, count_enable, count_latch,
        input  res_valid, res_in_phase, res_quadrature, res_windows, res_flags
    );

    modport slave (
        input  start, abort, cfg_window_cycles, cfg_num_windows, cfg_dark_enable,
        input  dp_valid, dp_in_phase, dp_quadrature, res_ready,
        output busy, light_enable, count_clear, count_enable, count_latch,
        output res_valid, res_in_phase, res_quadrature, res_windows, res_flags
    );
endinterface

// File: rtl/lockin_acquisition_sequencer.sv
// Sequences light/dark integration windows and accumulates saturating signed I/Q (light - dark).
// Per light window: SETTLE_CYCLES + 1 + W + 1 + dp latency + 1 clocks; the result is held while res_valid && !res_ready.
module lockin_acquisition_sequencer #(
    parameter int ACC_W         = 48,
    parameter int SETTLE_CYCLES = 1000,
    parameter int DP_TIMEOUT    = 255
) (
    input logic                           clock_50_mhz,
    input logic                           reset,
    lockin_acquisition_sequencer_if.slave sq
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CLEAR, S_COUNT, S_LATCH, S_WAIT_DP, S_UPDATE, S_PRESENT
    } state_t;

    localparam logic [31:0]      SETTLE_LIM = 32'(SETTLE_CYCLES);
    localparam logic [31:0]      DP_LIM     = 32'(DP_TIMEOUT);
    localparam logic [ACC_W-1:0] ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state_q;
    logic [31:0]      cnt_q, wait_q, cfg_w_q, smp_i_q, smp_q_q;
    logic [15:0]      cfg_n_q, win_q;
    logic             cfg_dark_q, dark_q;
    logic [ACC_W-1:0] acc_i_q, acc_q_q, acc_i_d, acc_q_d;
    logic             sat_i, sat_q;
    logic [1:0]       flags_q;
    logic             busy_q, light_q, clear_q, enable_q, latch_q, valid_q;

    // Sum is formed one bit wider so overflow shows as disagreement of the top two bits.
    function automatic logic [ACC_W:0] sat_acc(input logic [ACC_W-1:0] acc,
                                               input logic [31:0] smp, input logic sub);
        logic [ACC_W:0] a, s, r;
        a = {acc[ACC_W-1], acc};
        s = {{(ACC_W-31){smp[31]}}, smp};
        r = sub ? a - s : a + s;
        if (r[ACC_W] != r[ACC_W-1]) begin
            return {1'b1, r[ACC_W] ? ACC_MIN : ACC_MAX};
        end
        return {1'b0, r[ACC_W-1:0]};
    endfunction

    assign {sat_i, acc_i_d} = sat_acc(acc_i_q, smp_i_q, dark_q);
    assign {sat_q, acc_q_d} = sat_acc(acc_q_q, smp_q_q, dark_q);

    always_ff @(posedge clock_50_mhz) begin
        clear_q <= 1'b0;
        latch_q <= 1'b0;
        // Abort discards everything exactly like reset, except once the result is final.
        if (reset || (sq.abort && state_q != S_PRESENT)) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wait_q     <= '0;
            cfg_w_q    <= '0;
            cfg_n_q    <= '0;
            cfg_dark_q <= 1'b0;
            dark_q     <= 1'b0;
            win_q      <= '0;
            smp_i_q    <= '0;
            smp_q_q    <= '0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            flags_q    <= '0;
            busy_q     <= 1'b0;
            light_q    <= 1'b0;
            enable_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (sq.start) begin
                    cfg_w_q    <= (sq.cfg_window_cycles == 32'd0) ? 32'd1 : sq.cfg_window_cycles;
                    cfg_n_q    <= (sq.cfg_num_windows == 16'd0) ? 16'd1 : sq.cfg_num_windows;
                    cfg_dark_q <= sq.cfg_dark_enable;
                    acc_i_q    <= '0;
                    acc_q_q    <= '0;
                    flags_q    <= '0;
                    win_q      <= '0;
                    dark_q     <= 1'b0;
                    cnt_q      <= '0;
                    busy_q     <= 1'b1;
                    light_q    <= 1'b1;
                    state_q    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q + 32'd1 >= SETTLE_LIM) begin
                        cnt_q   <= '0;
                        clear_q <= 1'b1;
                        state_q <= S_CLEAR;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_CLEAR: begin
                    enable_q <= 1'b1;
                    state_q  <= S_COUNT;
                end
                S_COUNT: begin
                    if (cnt_q == cfg_w_q - 32'd1) begin
                        enable_q <= 1'b0;
                        latch_q  <= 1'b1;
                        state_q  <= S_LATCH;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_LATCH: begin
                    wait_q  <= '0;
                    state_q <= S_WAIT_DP;
                end
                S_WAIT_DP: begin
                    if (sq.dp_valid) begin
                        smp_i_q <= sq.dp_in_phase;
                        smp_q_q <= sq.dp_quadrature;
                        state_q <= S_UPDATE;
                    end else if (wait_q + 32'd1 >= DP_LIM) begin
                        smp_i_q    <= '0;
                        smp_q_q    <= '0;
                        flags_q[1] <= 1'b1;
                        state_q    <= S_UPDATE;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_UPDATE: begin
                    acc_i_q    <= acc_i_d;
                    acc_q_q    <= acc_q_d;
                    flags_q[0] <= flags_q[0] | sat_i | sat_q;
                    cnt_q      <= '0;
                    if (!dark_q && cfg_dark_q) begin
                        dark_q  <= 1'b1;
                        light_q <= 1'b0;
                        state_q <= S_SETTLE;
                    end else begin
                        win_q <= win_q + 16'd1;
                        if (win_q + 16'd1 == cfg_n_q) begin
                            light_q <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= S_PRESENT;
                        end else begin
                            dark_q  <= 1'b0;
                            light_q <= 1'b1;
                            state_q <= S_SETTLE;
                        end
                    end
                end
                S_PRESENT: if (sq.res_ready) begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sq.busy           = busy_q;
    assign sq.light_enable   = light_q;
    assign sq.count_clear    = clear_q;
    assign sq.count_enable   = enable_q;
    assign sq.count_latch    = latch_q;
    assign sq.res_valid      = valid_q;
    assign sq.res_in_phase   = acc_i_q;
    assign sq.res_quadrature = acc_q_q;
    assign sq.res_windows    = win_q;
    assign sq.res_flags      = flags_q;
endmodule
